cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/step/halt sequencer and program loader for the single-cycle RISC-V core. It loads instruction memory from a byte stream, then gates the program-counter update to run, single-step or halt the datapath. It stops on EBREAK, on a host command or, optionally, on a PC breakpoint, and keeps a retired-instruction count. It sits beside the PC register and instruction memory, driving their write-enable and update-enable inputs.

## Interface
- IMEM_AW, 8: instruction-memory word-address width (depth 2^IMEM_AW words)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_op  in  3  000 HALT, 001 RUN, 010 STEP, 011 LOAD, 100 CLRPC, others NOP
- cmd_len  in  IMEM_AW+1  LOAD word count, sampled at acceptance
- ld_valid  in  1  load byte valid
- ld_ready  out  1  load byte accepted when ld_valid & ld_ready
- ld_data  in  8  load byte, little-endian within each word
- imem_we  out  1  instruction-memory write strobe
- imem_waddr  out  IMEM_AW  word write address
- imem_wdata  out  32  write data
- inst  in  32  instruction currently fetched at pc
- pc  in  32  current PC
- brk_en  in  1  breakpoint enable
- brk_addr  in  32  breakpoint PC
- pc_en  out  1  PC/register-file update enable; low freezes the core
- pc_clr  out  1  one-cycle pulse forcing PC to 0
- state  out  2  0 IDLE, 1 LOAD, 2 RUN, 3 STEP
- halt_cause  out  2  00 command, 01 EBREAK, 10 breakpoint, 11 step done
- instret  out  32  retired-instruction counter

## Operation
- Reset values: state IDLE; halt_cause 00; instret 0; every strobe, address and data output 0.
- IDLE: cmd_ready=1. Accepted commands take effect as follows:
  - RUN: go to RUN.
  - STEP: go to STEP.
  - LOAD: go to LOAD, latch cmd_len, clear word address, byte index and instret.
  - CLRPC: pulse pc_clr, stay in IDLE.
  - HALT and NOP: ignored.
- LOAD:
  - ld_ready=1; cmd_ready=0.
  - Each accepted byte fills bits [8k+7:8k] for k=byte index 0..3.
  - On the 4th byte, the next cycle has imem_we=1 for one cycle with the assembled word at imem_waddr. imem_waddr then increments, wrapping at 2^IMEM_AW.
  - After cmd_len words have been written: pc_clr pulses, and the block returns to IDLE with halt_cause 00.
  - cmd_len=0: the next cycle pulses pc_clr and returns to IDLE with no writes.
  - ld_ready is low during the imem_we cycle.
- RUN:
  - cmd_ready=1. Only HALT acts; other commands are accepted and dropped.
  - Combinational enable: pc_en = !ebreak_hit & !bp_hit.
  - ebreak_hit = (inst == 32'h00100073).
  - bp_hit = brk_en & (pc == brk_addr).
  - On ebreak_hit: pc_en=0 that cycle, go to IDLE, halt_cause 01. The EBREAK is not retired.
  - On bp_hit: pc_en=0, go to IDLE, halt_cause 10. The instruction at brk_addr is not executed.
  - HALT accepted: the acceptance cycle still executes; go to IDLE, halt_cause 00.
- STEP:
  - One cycle long; cmd_ready=0.
  - pc_en = !ebreak_hit, then return to IDLE.
  - halt_cause is 11, or 01 if ebreak_hit. Breakpoints are ignored in STEP so a stopped core can step off a breakpoint.
- instret increments on every cycle with pc_en=1, wraps at 2^32, and is cleared only by reset or LOAD.

## Timing
- All state, counters and pc_clr, imem_* outputs are registered.
- pc_en is combinational from state, inst, pc, brk_en and brk_addr.
- Command latency: state changes at the accepting edge. The first RUN/STEP pc_en=1 is the cycle after acceptance.
- Load latency: last byte accepted at edge N; imem_we high during cycle N+1; pc_clr high and state IDLE at cycle N+2.
- Simultaneous HALT acceptance and ebreak_hit/bp_hit in RUN: the hit wins (pc_en=0, cause 01/10).
- Reset mid-LOAD: the partial word is dropped, nothing is written, and the block is in IDLE while rst_n is low.
- pc_en=0 in IDLE and LOAD.

## Configuration
- CPU_BRK_EN defined: PC breakpoint comparator built as above.
- CPU_BRK_EN undefined: bp_hit is constant 0. brk_en and brk_addr remain ports but are ignored, and halt_cause 10 never occurs.

## Test plan
- LOAD, cmd_len=2, bytes 13 05 50 00 93 05 a0 00:
  - imem writes 0x00500513@0, then 0x00a00593@1.
  - pc_clr pulses once, state returns to 0, instret=0.
- RUN over 5 NOPs followed by EBREAK:
  - pc_en high for exactly 5 cycles, pc_en=0 on the EBREAK cycle.
  - state=0, halt_cause=01, instret=5.
- CPU_BRK_EN, brk_en=1, brk_addr=0x8, RUN from pc 0:
  - halts with pc=0x8 not executed, halt_cause=10, instret=2.
  - STEP then executes 0x8: instret=3, halt_cause=11.
- RUN, HALT asserted on the 3rd RUN cycle:
  - instret=3, halt_cause=00.
  - A RUN issued during RUN is accepted with no effect.
- rst_n low after 2 LOAD bytes, then LOAD cmd_len=1 with 4 bytes:
  - no write from the first attempt.
  - a single write at address 0 with the new word.
- LOAD with cmd_len=0:
  - no imem_we.
  - pc_clr one cycle after acceptance, state 0 on the following cycle.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer and byte-stream program loader for the single-cycle core.
// Define CPU_BRK_EN to build the PC breakpoint comparator; otherwise brk_en/brk_addr are ignored.
module cpu_run_ctrl #(
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [IMEM_AW:0]   cmd_len,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [7:0]         ld_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  input  logic [31:0]        inst,
  input  logic [31:0]        pc,
  input  logic               brk_en,
  input  logic [31:0]        brk_addr,
  output logic               pc_en,
  output logic               pc_clr,
  output logic [1:0]         state,
  output logic [1:0]         halt_cause,
  output logic [31:0]        instret
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  localparam logic [2:0]       OP_HALT  = 3'b000;
  localparam logic [2:0]       OP_RUN   = 3'b001;
  localparam logic [2:0]       OP_STEP  = 3'b010;
  localparam logic [2:0]       OP_LOAD  = 3'b011;
  localparam logic [2:0]       OP_CLRPC = 3'b100;
  localparam logic [31:0]      EBREAK   = 32'h0010_0073;
  localparam logic [IMEM_AW:0] ONE_WORD = {{IMEM_AW{1'b0}}, 1'b1};

  state_t             state_r, state_next;
  logic [1:0]         cause_r, cause_next;
  logic [IMEM_AW:0]   left_r;
  logic [1:0]         byte_idx_r;
  logic [23:0]        word_r;
  logic               imem_we_r;
  logic [IMEM_AW-1:0] imem_waddr_r;
  logic [31:0]        imem_wdata_r;
  logic               pc_clr_r;
  logic [31:0]        instret_r;
  logic               ebreak_hit_s;
  logic               bp_hit_s;

  assign ebreak_hit_s = (inst == EBREAK);

`ifdef CPU_BRK_EN
  assign bp_hit_s = brk_en & (pc == brk_addr);
`else
  logic unused_brk_s;
  assign unused_brk_s = ^{brk_en, brk_addr, pc};
  assign bp_hit_s     = 1'b0;
`endif

  assign state      = state_r;
  assign halt_cause = cause_r;
  assign imem_we    = imem_we_r;
  assign imem_waddr = imem_waddr_r;
  assign imem_wdata = imem_wdata_r;
  assign pc_clr     = pc_clr_r;
  assign instret    = instret_r;

  // Next-state, halt cause and the combinational handshake/enable outputs
  always_comb begin
    state_next = state_r;
    cause_next = cause_r;
    cmd_ready  = 1'b0;
    ld_ready   = 1'b0;
    pc_en      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_RUN:  state_next = ST_RUN;
            OP_STEP: state_next = ST_STEP;
            OP_LOAD: state_next = ST_LOAD;
            default: state_next = ST_IDLE;
          endcase
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // No bytes are taken while a word is being written or when nothing is left
        ld_ready = !imem_we_r && (left_r != '0);
        if (imem_we_r) begin
          if (left_r == ONE_WORD) begin
            state_next = ST_IDLE;
            cause_next = 2'b00;
          end else begin
            state_next = ST_LOAD;
          end
        end else if (left_r == '0) begin
          state_next = ST_IDLE;
          cause_next = 2'b00;
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_RUN: begin
        cmd_ready = 1'b1;
        pc_en     = !ebreak_hit_s && !bp_hit_s;
        if (ebreak_hit_s) begin
          state_next = ST_IDLE;
          cause_next = 2'b01;
        end else if (bp_hit_s) begin
          state_next = ST_IDLE;
          cause_next = 2'b10;
        end else if (cmd_valid && (cmd_op == OP_HALT)) begin
          state_next = ST_IDLE;
          cause_next = 2'b00;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_STEP: begin
        pc_en      = !ebreak_hit_s;
        state_next = ST_IDLE;
        cause_next = ebreak_hit_s ? 2'b01 : 2'b11;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and halt-cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cause_r <= 2'b00;
    end else begin
      state_r <= state_next;
      cause_r <= cause_next;
    end
  end

  // Loader datapath, pc_clr strobe and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_r       <= '0;
      byte_idx_r   <= 2'd0;
      word_r       <= 24'd0;
      imem_we_r    <= 1'b0;
      imem_waddr_r <= '0;
      imem_wdata_r <= 32'd0;
      pc_clr_r     <= 1'b0;
      instret_r    <= 32'd0;
    end else begin
      pc_clr_r  <= 1'b0;
      imem_we_r <= 1'b0;
      if (pc_en) begin
        instret_r <= instret_r + 32'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && (cmd_op == OP_LOAD)) begin
            left_r       <= cmd_len;
            imem_waddr_r <= '0;
            byte_idx_r   <= 2'd0;
            instret_r    <= 32'd0;
            pc_clr_r     <= (cmd_len == '0);
          end else if (cmd_valid && (cmd_op == OP_CLRPC)) begin
            pc_clr_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (imem_we_r) begin
            imem_waddr_r <= imem_waddr_r + 1'b1;
            left_r       <= left_r - ONE_WORD;
            pc_clr_r     <= (left_r == ONE_WORD);
          end else if (ld_valid && ld_ready) begin
            case (byte_idx_r)
              2'd0:    word_r[7:0]   <= ld_data;
              2'd1:    word_r[15:8]  <= ld_data;
              2'd2:    word_r[23:16] <= ld_data;
              default: begin
                imem_we_r    <= 1'b1;
                imem_wdata_r <= {ld_data, word_r};
              end
            endcase
            byte_idx_r <= byte_idx_r + 2'd1;
          end
        end
        default: begin
          left_r <= left_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a tiny PC/imem core closes the loop, and a
// behavioural model of the sequencer is compared against the DUT every cycle.
module tb_cpu_run_ctrl;
  localparam int AW = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBR = 32'h0010_0073;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [AW:0]   cmd_len = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [7:0]    ld_data = 8'd0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   inst;
  logic [31:0]   pc;
  logic          brk_en = 1'b0;
  logic [31:0]   brk_addr = 32'd0;
  logic          pc_en;
  logic          pc_clr;
  logic [1:0]    state;
  logic [1:0]    halt_cause;
  logic [31:0]   instret;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.IMEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .inst(inst), .pc(pc), .brk_en(brk_en), .brk_addr(brk_addr),
    .pc_en(pc_en), .pc_clr(pc_clr), .state(state), .halt_cause(halt_cause), .instret(instret)
  );

  // Environment: PC register and instruction memory driven by the DUT strobes
  logic [31:0] mem [0:255];
  logic [31:0] pc_r;
  assign pc   = pc_r;
  assign inst = mem[pc_r[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= 32'd0;
      for (int i = 0; i < 256; i++) mem[i] <= NOP;
    end else begin
      if (imem_we) mem[imem_waddr] <= imem_wdata;
      if (pc_clr) pc_r <= 32'd0;
      else if (pc_en) pc_r <= pc_r + 32'd4;
    end
  end

  // Behavioural model: mode 0 idle, 1 load, 2 run, 3 step
  int          m_mode, m_bidx, m_left;
  logic [1:0]  m_cause;
  logic [31:0] m_instret, m_wdata, m_word;
  logic        m_pc_clr, m_we;
  logic [AW-1:0] m_waddr;
  logic        m_eb, m_bp, e_cmd_ready, e_ld_ready, e_pc_en;

  always_comb begin
    m_eb = (inst == EBR);
`ifdef CPU_BRK_EN
    m_bp = brk_en && (pc == brk_addr);
`else
    m_bp = 1'b0;
`endif
    e_cmd_ready = (m_mode == 0) || (m_mode == 2);
    e_ld_ready  = (m_mode == 1) && !m_we && (m_left != 0);
    e_pc_en     = ((m_mode == 2) && !m_eb && !m_bp) || ((m_mode == 3) && !m_eb);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_cause <= 2'd0; m_instret <= 32'd0; m_pc_clr <= 1'b0; m_we <= 1'b0;
      m_waddr <= '0; m_wdata <= 32'd0; m_word <= 32'd0; m_bidx <= 0; m_left <= 0;
    end else begin
      m_pc_clr <= 1'b0;
      m_we <= 1'b0;
      m_instret <= m_instret + (e_pc_en ? 32'd1 : 32'd0);
      if (m_mode == 0) begin
        if (cmd_valid && cmd_op == 3'd1) m_mode <= 2;
        if (cmd_valid && cmd_op == 3'd2) m_mode <= 3;
        if (cmd_valid && cmd_op == 3'd4) m_pc_clr <= 1'b1;
        if (cmd_valid && cmd_op == 3'd3) begin
          m_mode <= 1; m_left <= int'(cmd_len); m_waddr <= '0; m_bidx <= 0;
          m_instret <= 32'd0; m_pc_clr <= (cmd_len == '0);
        end
      end else if (m_mode == 1) begin
        if (m_we) begin
          m_waddr <= m_waddr + 1'b1;
          m_left <= m_left - 1;
          if (m_left == 1) begin m_pc_clr <= 1'b1; m_mode <= 0; m_cause <= 2'd0; end
        end else if (m_left == 0) begin
          m_mode <= 0; m_cause <= 2'd0;
        end else if (ld_valid && e_ld_ready) begin
          if (m_bidx == 3) begin
            m_we <= 1'b1; m_wdata <= {ld_data, m_word[23:0]}; m_bidx <= 0;
          end else begin
            m_word[8*m_bidx +: 8] <= ld_data; m_bidx <= m_bidx + 1;
          end
        end
      end else if (m_mode == 2) begin
        if (m_eb) begin m_mode <= 0; m_cause <= 2'd1; end
        else if (m_bp) begin m_mode <= 0; m_cause <= 2'd2; end
        else if (cmd_valid && cmd_op == 3'd0) begin m_mode <= 0; m_cause <= 2'd0; end
      end else begin
        m_mode <= 0; m_cause <= m_eb ? 2'd1 : 2'd3;
      end
    end
  end

  int total = 0, bad = 0;
  int n_pc_en = 0, n_pc_clr = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_mode));
    chk("halt_cause", 32'(halt_cause), 32'(m_cause));
    chk("instret", instret, m_instret);
    chk("pc_en", 32'(pc_en), 32'(e_pc_en));
    chk("pc_clr", 32'(pc_clr), 32'(m_pc_clr));
    chk("imem_we", 32'(imem_we), 32'(m_we));
    chk("cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
    chk("ld_ready", 32'(ld_ready), 32'(e_ld_ready));
    if (m_we) begin
      chk("imem_waddr", 32'(imem_waddr), 32'(m_waddr));
      chk("imem_wdata", imem_wdata, m_wdata);
    end
    if (pc_en) n_pc_en++;
    if (pc_clr) n_pc_clr++;
    if (imem_we) begin wa_q.push_back(imem_waddr); wd_q.push_back(imem_wdata); end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input int len);
    int n = 0;
    cmd_op = op; cmd_len = (AW+1)'(len); cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL cmd_timeout: cmd_ready stayed %b, required 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    ld_data = b; ld_valid = 1'b1;
    while (!ld_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL ld_timeout: ld_ready stayed %b, required 1", ld_ready); end
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (state != 2'd0 && n < 200) begin tick(); n++; end
    if (n >= 200) begin total++; bad++; $display("FAIL idle_timeout: state %0d, required 0", state); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p0, c0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cause", 32'(halt_cause), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_waddr", 32'(imem_waddr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_pc_clr", 32'(pc_clr), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    rst_n = 1'b1;
    tick();

    // Two-word load, little-endian bytes
    base = wa_q.size(); c0 = n_pc_clr;
    send_cmd(3'd3, 2);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'ha0); send_byte(8'h00);
    wait_idle();
    chk("load2_nwr", 32'(wa_q.size() - base), 32'd2);
    chk("load2_a0", 32'(wa_q[base]), 32'd0);
    chk("load2_d0", wd_q[base], 32'h0050_0513);
    chk("load2_a1", 32'(wa_q[base+1]), 32'd1);
    chk("load2_d1", wd_q[base+1], 32'h00a0_0593);
    chk("load2_pcclr", 32'(n_pc_clr - c0), 32'd1);
    chk("load2_state", 32'(state), 32'd0);
    chk("load2_instret", instret, 32'd0);

    // Five NOPs then EBREAK
    send_cmd(3'd3, 6);
    for (int i = 0; i < 5; i++) send_word(NOP);
    send_word(EBR);
    wait_idle();
    p0 = n_pc_en;
    send_cmd(3'd1, 0);
    wait_idle();
    chk("run_pcen_cycles", 32'(n_pc_en - p0), 32'd5);
    chk("run_state", 32'(state), 32'd0);
    chk("run_cause", 32'(halt_cause), 32'd1);
    chk("run_instret", instret, 32'd5);
    send_cmd(3'd2, 0);
    tick();
    chk("step_ebreak_cause", 32'(halt_cause), 32'd1);
    chk("step_ebreak_instret", instret, 32'd5);

    // Breakpoint at 0x8 over a fresh four-NOP load
    send_cmd(3'd3, 4);
    for (int i = 0; i < 4; i++) send_word(NOP);
    wait_idle();
    brk_en = 1'b1; brk_addr = 32'h8;
    send_cmd(3'd1, 0);
    wait_idle();
`ifdef CPU_BRK_EN
    chk("bp_cause", 32'(halt_cause), 32'd2);
    chk("bp_instret", instret, 32'd2);
    chk("bp_pc", pc, 32'h8);
    send_cmd(3'd2, 0);
    tick();
    chk("bp_step_instret", instret, 32'd3);
    chk("bp_step_cause", 32'(halt_cause), 32'd3);
`else
    chk("nobp_cause", 32'(halt_cause), 32'd1);
    chk("nobp_instret", instret, 32'd5);
`endif
    brk_en = 1'b0;

    // HALT on the third RUN cycle, with a dropped RUN inside RUN
    send_cmd(3'd3, 4);
    for (int i = 0; i < 4; i++) send_word(NOP);
    wait_idle();
    send_cmd(3'd1, 0);
    send_cmd(3'd1, 0);
    tick();
    send_cmd(3'd0, 0);
    tick();
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_cause", 32'(halt_cause), 32'd0);
    chk("halt_instret", instret, 32'd3);
    send_cmd(3'd4, 0);
    chk("clrpc_pulse", 32'(pc_clr), 32'd1);
    tick();
    chk("clrpc_pc", pc, 32'd0);

    // Reset in the middle of a load
    base = wa_q.size();
    send_cmd(3'd3, 1);
    send_byte(8'haa); send_byte(8'hbb);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mid_rst_nowr", 32'(wa_q.size() - base), 32'd0);
    send_cmd(3'd3, 1);
    send_word(32'h1234_5678);
    wait_idle();
    chk("reload_nwr", 32'(wa_q.size() - base), 32'd1);
    chk("reload_addr", 32'(wa_q[base]), 32'd0);
    chk("reload_data", wd_q[base], 32'h1234_5678);

    // Zero-length load
    base = wa_q.size();
    send_cmd(3'd3, 0);
    chk("len0_pcclr", 32'(pc_clr), 32'd1);
    chk("len0_state_load", 32'(state), 32'd1);
    tick();
    chk("len0_pcclr_off", 32'(pc_clr), 32'd0);
    chk("len0_state_idle", 32'(state), 32'd0);
    tick();
    chk("len0_nowr", 32'(wa_q.size() - base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
